inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), meaning the instruction presented while no valid fetch is held.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall_i  input  1  downstream cannot accept the current instruction; hold it.
REQ-006 pc_sel_i  input  1  1 = next PC is target_i; 0 = next PC is PC+4. Driven by the decode stage.
REQ-007 target_i  input  32  branch/jalr target from the ALU.
REQ-008 imem_req_o  output  1  instruction-memory read request.
REQ-009 imem_addr_o  output  32  read address; always equals pc_o.
REQ-010 imem_ack_i  input  1  read data valid this cycle.
REQ-011 imem_rdata_i  input  32  instruction word, sampled only when imem_ack_i=1.
REQ-012 pc_o  output  32  address of the instruction on inst_o.
REQ-013 inst_o  output  32  fetched instruction; feeds the decoder inst_i.
REQ-014 inst_valid_o  output  1  inst_o/pc_o valid for decode and execute this cycle.
REQ-015 misalign_o  output  1  sticky fault: a taken target had target_i[1:0] != 0.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, ISSUE, HALT.
REQ-017 IDLE: all outputs at reset values; next state REQ unconditionally.
REQ-018 REQ: imem_req_o=1. imem_ack_i=1 -> capture imem_rdata_i into inst_o and go to ISSUE. Otherwise go to WAIT.
REQ-019 WAIT: imem_req_o=1 and imem_addr_o held stable. imem_ack_i=1 -> capture into inst_o and go to ISSUE. Otherwise remain in WAIT; no timeout.
REQ-020 ISSUE: inst_valid_o=1, imem_req_o=0.
REQ-021 ISSUE with stall_i=1: remain in ISSUE with pc_o and inst_o unchanged.
REQ-022 ISSUE with stall_i=0 and pc_sel_i=0: pc <= pc+4 and go to REQ.
REQ-023 ISSUE with stall_i=0 and pc_sel_i=1 and target_i[1:0]==0: pc <= target_i and go to REQ.
REQ-024 ISSUE with stall_i=0 and pc_sel_i=1 and target_i[1:0]!=0: go to HALT, pc unchanged, misalign_o <= 1.
REQ-025 HALT: imem_req_o=0, inst_valid_o=0, inst_o=NOP_INST; remain until rst.
REQ-026 pc_sel_i, target_i and stall_i SHALL be ignored outside ISSUE.
REQ-027 imem_ack_i and imem_rdata_i SHALL be ignored outside REQ and WAIT.
REQ-028 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000; wrap is not a fault.
REQ-029 inst_o SHALL read NOP_INST whenever inst_valid_o=0, except while held in ISSUE.
REQ-030 Minimum throughput: one instruction per 2 cycles (REQ->ISSUE, zero-wait ack). Each memory wait cycle adds one cycle.

Reset
REQ-031 rst=1 at a clock edge -> next state IDLE, pc_o=RESET_PC, inst_o=NOP_INST, inst_valid_o=0, imem_req_o=0, misalign_o=0.
REQ-032 Reset asserted in any state, including WAIT with an outstanding request, SHALL abandon the operation. An ack arriving in IDLE after reset SHALL be ignored.
REQ-033 With rst held high, outputs SHALL remain at reset values; the first request issues 2 cycles after rst falls (IDLE, then REQ).

Verification
REQ-034 Zero-wait memory, pc_sel_i=0, no stall -> imem_addr_o sequence 0,4,8,C; inst_valid_o high on every second cycle.
REQ-035 ack delayed 3 cycles at PC=8 -> imem_addr_o=8 held for 4 req cycles; inst_o=rdata presented once; next address C.
REQ-036 In ISSUE at PC=10, pc_sel_i=1, target_i=0x40 -> next imem_addr_o=0x40.
REQ-037 stall_i=1 for 5 cycles in ISSUE -> inst_o and pc_o constant; no imem_req_o; after release next address PC+4.
REQ-038 pc_sel_i=1, target_i=0x42 -> HALT; misalign_o=1; imem_req_o=0 until rst, then fetch from RESET_PC.
REQ-039 rst pulsed in WAIT, ack arriving the following cycle -> ack ignored; inst_valid_o=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: control from decode/ALU, instruction-memory handshake, and
// the instruction issued to decode.
interface inst_fetch_if;
   logic        stall_i;
   logic        pc_sel_i;
   logic [31:0] target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic        misalign_o;

   modport master (
      input  stall_i, pc_sel_i, target_i, imem_ack_i, imem_rdata_i,
      output imem_req_o, imem_addr_o, pc_o, inst_o, inst_valid_o, misalign_o
   );

   modport slave (
      output stall_i, pc_sel_i, target_i, imem_ack_i, imem_rdata_i,
      input  imem_req_o, imem_addr_o, pc_o, inst_o, inst_valid_o, misalign_o
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests one word per PC, issues it to decode, and
// follows sequential or redirected flow; a misaligned redirect halts until reset.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input logic        clk,
   input logic        rst,
   inst_fetch_if.master bus
);

   localparam int unsigned XLEN    = 32;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      ISSUE,
      HALT
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] inst;
   logic            req;
   logic            valid;
   logic            misalign;

   // All outputs are registered alongside the state so they reflect the state entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         inst     <= NOP_INST;
         req      <= 1'b0;
         valid    <= 1'b0;
         misalign <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
               req   <= 1'b1;
            end
            REQ, WAIT: begin
               if (bus.imem_ack_i) begin
                  state <= ISSUE;
                  inst  <= bus.imem_rdata_i;
                  req   <= 1'b0;
                  valid <= 1'b1;
               end else begin
                  state <= WAIT;
               end
            end
            ISSUE: begin
               if (!bus.stall_i) begin
                  valid <= 1'b0;
                  inst  <= NOP_INST;
                  if (!bus.pc_sel_i) begin
                     state <= REQ;
                     req   <= 1'b1;
                     pc    <= pc + PC_STEP;
                  end else if (bus.target_i[1:0] == 2'b00) begin
                     state <= REQ;
                     req   <= 1'b1;
                     pc    <= bus.target_i;
                  end else begin
                     state    <= HALT;
                     misalign <= 1'b1;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
               req   <= 1'b0;
               valid <= 1'b0;
               inst  <= NOP_INST;
            end
         endcase
      end
   end

   assign bus.imem_req_o   = req;
   assign bus.imem_addr_o  = pc;
   assign bus.pc_o         = pc;
   assign bus.inst_o       = inst;
   assign bus.inst_valid_o = valid;
   assign bus.misalign_o   = misalign;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a transaction-level PC model predicts fetch
// addresses and issued words; a monitor compares the DUT against them.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam int unsigned N_CYCLES = 4000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   inst_fetch_if bus ();

   inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t        exp_q[$];
   logic [31:0] model_pc  = RESET_PC;
   logic        halt_exp  = 1'b0;
   int          checks    = 0;
   int          passed    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
   endtask

   // Stimulus and reference model: inputs driven 2ns after each rising edge.
   initial begin
      int halt_cycles;
      logic [4:0] r;
      logic do_rst;
      logic [31:0] tgt;
      halt_cycles = 0;
      bus.stall_i = 1'b0;
      bus.pc_sel_i = 1'b0;
      bus.target_i = '0;
      bus.imem_ack_i = 1'b0;
      bus.imem_rdata_i = '0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(posedge clk);
         #2;
         do_rst = 1'b0;
         if (halt_exp) begin
            halt_cycles++;
            if (halt_cycles > 5) do_rst = 1'b1;
         end
         if ($urandom_range(0, 199) == 0) do_rst = 1'b1;
         if (bus.imem_req_o && $urandom_range(0, 59) == 0) do_rst = 1'b1;

         bus.stall_i      = ($urandom_range(0, 9) < 3);
         bus.pc_sel_i     = ($urandom_range(0, 3) == 0);
         bus.imem_ack_i   = ($urandom_range(0, 1) == 1);
         bus.imem_rdata_i = $urandom;
         r = 5'($urandom_range(0, 19));
         if (r == 0) tgt = 32'hFFFF_FFFC;
         else if (r <= 2) tgt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
         else tgt = $urandom & 32'hFFFF_FFFC;
         bus.target_i = tgt;

         if (do_rst) begin
            rst = 1'b1;
            model_pc = RESET_PC;
            exp_q.delete();
            halt_exp = 1'b0;
            halt_cycles = 0;
         end else begin
            rst = 1'b0;
            if (bus.imem_req_o && bus.imem_ack_i)
               exp_q.push_back('{pc: model_pc, inst: bus.imem_rdata_i});
            if (bus.inst_valid_o && !bus.stall_i) begin
               if (!bus.pc_sel_i) model_pc = model_pc + 32'd4;
               else if (bus.target_i[1:0] == 2'b00) model_pc = bus.target_i;
               else halt_exp = 1'b1;
            end
         end
      end
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() <= 1) passed++;
      else $display("FAIL leftover_queue: got %0d entries required <=1", exp_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Monitor: compares DUT outputs on every falling edge.
   initial begin
      logic rst_prev;
      logic halt_armed;
      int   quiet;
      exp_t e;
      rst_prev = 1'b1;
      halt_armed = 1'b0;
      quiet = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (rst_prev) begin
               chk("rst_pc", bus.pc_o, RESET_PC);
               chk("rst_inst", bus.inst_o, NOP_INST);
               chk("rst_valid", 32'(bus.inst_valid_o), 32'd0);
               chk("rst_req", 32'(bus.imem_req_o), 32'd0);
               chk("rst_misalign", 32'(bus.misalign_o), 32'd0);
            end
            halt_armed = 1'b0;
            quiet = 0;
         end else begin
            if (halt_armed) begin
               chk("halt_misalign", 32'(bus.misalign_o), 32'd1);
               chk("halt_req", 32'(bus.imem_req_o), 32'd0);
               chk("halt_valid", 32'(bus.inst_valid_o), 32'd0);
               chk("halt_inst", bus.inst_o, NOP_INST);
               chk("halt_pc", bus.pc_o, model_pc);
            end else begin
               chk("misalign_clear", 32'(bus.misalign_o), 32'd0);
            end
            if (bus.imem_req_o) begin
               chk("fetch_addr", bus.imem_addr_o, model_pc);
               chk("req_no_valid", 32'(bus.inst_valid_o), 32'd0);
            end
            if (bus.inst_valid_o) begin
               checks++;
               if (exp_q.size() == 0) begin
                  $display("FAIL issue_unexpected: got pc %h with no fetch outstanding", bus.pc_o);
               end else begin
                  passed++;
                  e = exp_q[0];
                  chk("issue_pc", bus.pc_o, e.pc);
                  chk("issue_inst", bus.inst_o, e.inst);
                  if (!bus.stall_i) void'(exp_q.pop_front());
               end
            end else begin
               chk("idle_inst_nop", bus.inst_o, NOP_INST);
            end
            if (bus.imem_req_o || bus.inst_valid_o || halt_armed) quiet = 0;
            else quiet++;
            if (quiet > 40) begin
               checks++;
               $display("FAIL progress_timeout: got %0d quiet cycles required <=40", quiet);
               quiet = 0;
            end
            if (halt_exp) halt_armed = 1'b1;
         end
         rst_prev = rst;
      end
   end

endmodule
